// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states, trap causes, datapath selects.
// RV32M_EN adds the MDU_BUSY state and makes OP with func7=0000001 legal.
// No logic here; consumers import ctrl_pkg::*.
package ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef RV32M_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
`ifdef RV32M_EN
      TRAP      = 3'd5,
      MDU_BUSY  = 3'd6
`else
      TRAP      = 3'd5
`endif
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_BUS_ERR = 2'd2,
      CAUSE_IRQ     = 2'd3
   } trap_cause_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } immed_e;

   typedef enum logic [1:0] {
      ALU_A_RS1  = 2'd0,
      ALU_A_PC   = 2'd1,
      ALU_A_ZERO = 2'd2
   } alu_a_e;

   typedef enum logic {
      ALU_B_RS2 = 1'b0,
      ALU_B_IMM = 1'b1
   } alu_b_e;

   // alu_op is {func7[5], func3} so the ALU can decode RISC-V fields directly
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      RS_ALU = 2'd0,
      RS_MEM = 2'd1,
      RS_PC4 = 2'd2,
      RS_CSR = 2'd3
   } reg_src_e;

   typedef enum logic [2:0] {
      PC_PLUS_4 = 3'd0,
      ALU_OUT   = 3'd1,
      CSR_MTVEC = 3'd2,
      CSR_MEPC  = 3'd3
   } pc_src_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: datapath selects and the illegal-instruction flag.
// Latency: zero cycles, purely combinational.
// No handshake; outputs follow opcode/func3/func7 directly.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic       illegal,
   output logic [2:0] immed_type,
   output logic [1:0] alu_a_src,
   output logic       alu_b_src,
   output logic [3:0] alu_op,
   output logic [1:0] reg_src,
   output logic [2:0] pc_src
);

   always_comb begin
      illegal    = 1'b0;
      immed_type = IMM_NONE;
      alu_a_src  = ALU_A_RS1;
      alu_b_src  = ALU_B_RS2;
      alu_op     = ALU_ADD;
      reg_src    = RS_ALU;
      pc_src     = PC_PLUS_4;
      case (opcode)
         OPC_LOAD: begin
            immed_type = IMM_I;
            alu_b_src  = ALU_B_IMM;
            reg_src    = RS_MEM;
         end
         OPC_STORE: begin
            immed_type = IMM_S;
            alu_b_src  = ALU_B_IMM;
         end
         OPC_BRANCH: begin
            immed_type = IMM_B;
            alu_a_src  = ALU_A_PC;
            alu_b_src  = ALU_B_IMM;
         end
         OPC_JAL: begin
            immed_type = IMM_J;
            alu_a_src  = ALU_A_PC;
            alu_b_src  = ALU_B_IMM;
            reg_src    = RS_PC4;
            pc_src     = ALU_OUT;
         end
         OPC_JALR: begin
            immed_type = IMM_I;
            alu_b_src  = ALU_B_IMM;
            reg_src    = RS_PC4;
            pc_src     = ALU_OUT;
         end
         OPC_LUI: begin
            immed_type = IMM_U;
            alu_a_src  = ALU_A_ZERO;
            alu_b_src  = ALU_B_IMM;
         end
         OPC_AUIPC: begin
            immed_type = IMM_U;
            alu_a_src  = ALU_A_PC;
            alu_b_src  = ALU_B_IMM;
         end
         OPC_OP_IMM: begin
            immed_type = IMM_I;
            alu_b_src  = ALU_B_IMM;
            // only right shifts use func7[5] to pick arithmetic vs logical
            alu_op     = (func3 == 3'b101) ? {func7[5], func3} : {1'b0, func3};
         end
         OPC_OP: begin
            alu_op = {func7[5], func3};
            if (func7 == F7_MULDIV)
               illegal = !M_EXT;
            else if (func7 != F7_BASE && func7 != F7_ALT)
               illegal = 1'b1;
         end
         OPC_SYSTEM: begin
            immed_type = IMM_I;
            alu_b_src  = ALU_B_IMM;
            reg_src    = RS_CSR;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32 control FSM with memory-wait timeout and traps; RV32M_EN adds an MDU busy state.
// Latency: FETCH/MEM wait on mem_ready up to MEM_TIMEOUT cycles, other states take one cycle.
// mem_req is held stable until mem_ready or timeout; all strobes are single-cycle pulses.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int MDU_CYCLES  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       take_branch,
   input  logic       mem_ready,
   input  logic       irq_pending,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic       csr_we,
   output logic       trap_start,
   output logic       trap_finish,
   output logic [1:0] trap_cause,
   output logic [2:0] immed_type,
   output logic [1:0] alu_a_src,
   output logic       alu_b_src,
   output logic [3:0] alu_op,
   output logic [1:0] reg_src,
   output logic [2:0] pc_src,
   output logic [2:0] state
);

   if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || MDU_CYCLES < 1 || MDU_CYCLES > 64) begin : g_bad_param
      $error("ctrl_fsm: parameter out of range");
   end

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   trap_cause_e cause_q, cause_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        dec_illegal;
   logic [2:0]  dec_pc_src;
   pc_src_e     pcs_c;
   logic        req_c, we_c, asel_c, ir_c, pc_c, rf_c, csr_c, ts_c, tf_c;
   logic        mem_phase, timeout;

`ifdef RV32M_EN
   localparam logic [6:0] MDU_LAST = 7'(MDU_CYCLES - 1);
   logic [6:0] mdu_cnt_q, mdu_cnt_d;
`endif

   ctrl_decode u_decode (
      .opcode     (opcode),
      .func3      (func3),
      .func7      (func7),
      .illegal    (dec_illegal),
      .immed_type (immed_type),
      .alu_a_src  (alu_a_src),
      .alu_b_src  (alu_b_src),
      .alu_op     (alu_op),
      .reg_src    (reg_src),
      .pc_src     (dec_pc_src)
   );

   assign mem_phase = (state_q == FETCH) || (state_q == MEM);
   // ready on the last permitted cycle still completes the access
   assign timeout   = mem_phase && !mem_ready && (wait_cnt_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      wait_cnt_d = (mem_phase && !mem_ready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
      pcs_c      = pc_src_e'(dec_pc_src);
      req_c      = 1'b0;
      we_c       = 1'b0;
      asel_c     = 1'b0;
      ir_c       = 1'b0;
      pc_c       = 1'b0;
      rf_c       = 1'b0;
      csr_c      = 1'b0;
      ts_c       = 1'b0;
      tf_c       = 1'b0;
`ifdef RV32M_EN
      mdu_cnt_d  = (state_q == MDU_BUSY) ? mdu_cnt_q + 7'd1 : 7'd0;
`endif
      case (state_q)
         FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               ir_c    = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_BUS_ERR;
            end
         end
         DECODE: begin
            if (dec_illegal) begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else if (irq_pending) begin
               state_d = TRAP;
               cause_d = CAUSE_IRQ;
            end else begin
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
               state_d = MEM;
            end else if (opcode == OPC_BRANCH) begin
               pc_c    = 1'b1;
               pcs_c   = take_branch ? ALU_OUT : PC_PLUS_4;
               state_d = FETCH;
            end else if (opcode == OPC_SYSTEM && func3 == 3'b000) begin
               tf_c    = 1'b1;
               pc_c    = 1'b1;
               pcs_c   = CSR_MEPC;
               state_d = FETCH;
`ifdef RV32M_EN
            end else if (opcode == OPC_OP && func7 == F7_MULDIV) begin
               state_d = MDU_BUSY;
`endif
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEM: begin
            req_c  = 1'b1;
            asel_c = 1'b1;
            we_c   = (opcode == OPC_STORE);
            if (mem_ready) begin
               if (opcode == OPC_STORE) begin
                  pc_c    = 1'b1;
                  pcs_c   = PC_PLUS_4;
                  state_d = FETCH;
               end else begin
                  state_d = WRITEBACK;
               end
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_BUS_ERR;
            end
         end
         WRITEBACK: begin
            rf_c    = 1'b1;
            csr_c   = (opcode == OPC_SYSTEM) && (func3 != 3'b000);
            pc_c    = 1'b1;
            state_d = FETCH;
         end
         TRAP: begin
            ts_c    = 1'b1;
            pc_c    = 1'b1;
            pcs_c   = CSR_MTVEC;
            state_d = FETCH;
         end
`ifdef RV32M_EN
         MDU_BUSY: begin
            if (mdu_cnt_q == MDU_LAST)
               state_d = WRITEBACK;
         end
`endif
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         cause_q    <= CAUSE_NONE;
         wait_cnt_q <= 8'd0;
`ifdef RV32M_EN
         mdu_cnt_q  <= 7'd0;
`endif
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         wait_cnt_q <= wait_cnt_d;
`ifdef RV32M_EN
         mdu_cnt_q  <= mdu_cnt_d;
`endif
      end
   end

   // gating with rst_n drops the bus request the instant reset asserts
   assign mem_req      = req_c & rst_n;
   assign mem_we       = we_c & rst_n;
   assign mem_addr_sel = asel_c;
   assign ir_we        = ir_c & rst_n;
   assign pc_we        = pc_c & rst_n;
   assign rf_we        = rf_c & rst_n;
   assign csr_we       = csr_c & rst_n;
   assign trap_start   = ts_c & rst_n;
   assign trap_finish  = tf_c & rst_n;
   assign trap_cause   = (rst_n && state_q == TRAP) ? cause_q : CAUSE_NONE;
   assign pc_src       = pcs_c;
   assign state        = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a per-instruction trace model built from the state rules,
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_ctrl_fsm;
   import ctrl_pkg::*;

   localparam int TO  = 4;
   localparam int MDC = 4;
   localparam logic [2:0] ST_MDU = 3'd6;
`ifdef RV32M_EN
   localparam bit HAS_M = 1'b1;
`else
   localparam bit HAS_M = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [6:0] opcode, func7;
   logic [2:0] func3;
   logic take_branch, mem_ready, irq_pending;
   logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, csr_we, trap_start, trap_finish;
   logic [1:0] trap_cause, alu_a_src, reg_src;
   logic [2:0] immed_type, pc_src, state;
   logic alu_b_src;
   logic [3:0] alu_op;

   always #5 clk = ~clk;

   ctrl_fsm #(.MEM_TIMEOUT(TO), .MDU_CYCLES(MDC)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
      .take_branch(take_branch), .mem_ready(mem_ready), .irq_pending(irq_pending),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .csr_we(csr_we),
      .trap_start(trap_start), .trap_finish(trap_finish), .trap_cause(trap_cause),
      .immed_type(immed_type), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
      .alu_op(alu_op), .reg_src(reg_src), .pc_src(pc_src), .state(state)
   );

   typedef struct {
      logic [2:0] st;
      logic rdy, req, we, asel, ir, pc, rf, csr, ts, tf;
      logic [1:0] cause;
      logic [2:0] pcs;
      logic rs_chk;
      logic [1:0] rs;
   } rec_t;

   typedef struct {
      string name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic tb, irq;
      int fw, mw;
   } vec_t;

   rec_t q[$];
   logic [2:0] obs[$];
   logic [3:0] ex_alu_op;
   logic [1:0] last_cause;
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic tb, logic irq, int fw, int mw);
      vec_t v;
      v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.tb = tb; v.irq = irq; v.fw = fw; v.mw = mw;
      return v;
   endfunction

   function automatic rec_t mk(logic [2:0] st);
      rec_t r = '{default: 0};
      r.st = st;
      return r;
   endfunction

   function automatic bit legal(logic [6:0] op, logic [6:0] f7);
      if (op == OPC_OP)
         return (f7 == 7'h00) || (f7 == 7'h20) || (HAS_M && f7 == 7'h01);
      return op inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                        OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_SYSTEM};
   endfunction

   task automatic push_trap(logic [1:0] c);
      rec_t r = mk(TRAP);
      r.ts = 1; r.pc = 1; r.pcs = CSR_MTVEC; r.cause = c;
      q.push_back(r);
   endtask

   // w = cycles of mem_ready low before it rises; w >= TO means it never rises in time
   task automatic push_access(logic [2:0] st, int w, bit store, output bit to);
      rec_t r;
      int n = (w >= TO) ? TO : w;
      for (int i = 0; i < n; i++) begin
         r = mk(st); r.req = 1; r.asel = (st == MEM); r.we = store;
         q.push_back(r);
      end
      to = (w >= TO);
      if (to) begin
         push_trap(CAUSE_BUS_ERR);
      end else begin
         r = mk(st); r.req = 1; r.asel = (st == MEM); r.we = store; r.rdy = 1;
         r.ir = (st == FETCH);
         if (store) begin r.pc = 1; r.pcs = PC_PLUS_4; end
         q.push_back(r);
      end
   endtask

   task automatic build(input vec_t v);
      rec_t r;
      bit to;
      q.delete();
      push_access(FETCH, v.fw, 1'b0, to);
      if (to) return;
      q.push_back(mk(DECODE));
      if (!legal(v.op, v.f7)) begin push_trap(CAUSE_ILLEGAL); return; end
      if (v.irq) begin push_trap(CAUSE_IRQ); return; end
      r = mk(EXECUTE);
      if (v.op == OPC_BRANCH) begin
         r.pc = 1; r.pcs = v.tb ? ALU_OUT : PC_PLUS_4;
         q.push_back(r);
         return;
      end
      if (v.op == OPC_SYSTEM && v.f3 == 3'b000) begin
         r.tf = 1; r.pc = 1; r.pcs = CSR_MEPC;
         q.push_back(r);
         return;
      end
      q.push_back(r);
      if (v.op == OPC_LOAD || v.op == OPC_STORE) begin
         push_access(MEM, v.mw, v.op == OPC_STORE, to);
         if (to || v.op == OPC_STORE) return;
      end
      if (HAS_M && v.op == OPC_OP && v.f7 == 7'h01)
         for (int i = 0; i < MDC; i++) q.push_back(mk(ST_MDU));
      r = mk(WRITEBACK);
      r.rf = 1; r.pc = 1;
      r.csr = (v.op == OPC_SYSTEM) && (v.f3 != 3'b000);
      r.pcs = (v.op == OPC_JAL || v.op == OPC_JALR) ? ALU_OUT : PC_PLUS_4;
      r.rs_chk = 1;
      r.rs = (v.op == OPC_LOAD) ? RS_MEM :
             (v.op == OPC_JAL || v.op == OPC_JALR) ? RS_PC4 :
             (v.op == OPC_SYSTEM) ? RS_CSR : RS_ALU;
      q.push_back(r);
   endtask

   // starts just after a rising edge, in the vector's first FETCH cycle
   task automatic run(input vec_t v);
      string p;
      rec_t e;
      build(v);
      opcode = v.op; func3 = v.f3; func7 = v.f7; take_branch = v.tb; irq_pending = v.irq;
      obs.delete();
      ex_alu_op = 4'hF;
      last_cause = 2'd0;
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         mem_ready = e.rdy;
         @(negedge clk);
         p = $sformatf("%s[%0d]", v.name, i);
         chk({p, " state"}, state, e.st);
         chk({p, " mem_req"}, mem_req, e.req);
         chk({p, " mem_we"}, mem_we, e.we);
         if (e.req) chk({p, " mem_addr_sel"}, mem_addr_sel, e.asel);
         chk({p, " ir_we"}, ir_we, e.ir);
         chk({p, " pc_we"}, pc_we, e.pc);
         chk({p, " rf_we"}, rf_we, e.rf);
         chk({p, " csr_we"}, csr_we, e.csr);
         chk({p, " trap_start"}, trap_start, e.ts);
         chk({p, " trap_finish"}, trap_finish, e.tf);
         chk({p, " trap_cause"}, trap_cause, e.cause);
         if (e.pc) chk({p, " pc_src"}, pc_src, e.pcs);
         if (e.rs_chk) chk({p, " reg_src"}, reg_src, e.rs);
         obs.push_back(state);
         if (state == EXECUTE) ex_alu_op = alu_op;
         if (trap_start) last_cause = trap_cause;
         @(posedge clk);
         #1;
      end
      irq_pending = 1'b0;
      mem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      opcode = OPC_OP_IMM; func3 = 3'b000; func7 = 7'h00;
      take_branch = 1'b0; irq_pending = 1'b0; mem_ready = 1'b1;
      #12;
      chk("reset state", state, 3'd0);
      chk("reset mem_req", mem_req, 1'b0);
      chk("reset ir_we", ir_we, 1'b0);
      chk("reset pc_we", pc_we, 1'b0);
      chk("reset trap_cause", trap_cause, 2'd0);
      mem_ready = 1'b0;
      #4 rst_n = 1'b1;

      run(mkv("addi", OPC_OP_IMM, 3'b000, 7'h00, 0, 0, 2, 0));
      chk("addi_len", obs.size(), 6);
      chk("addi_seq", {obs[0], obs[1], obs[2], obs[3], obs[4], obs[5]}, 18'o000124);
      chk("addi_alu_op", ex_alu_op, 4'b0000);

      run(mkv("lw", OPC_LOAD, 3'b010, 7'h00, 0, 0, 0, 2));
      chk("lw_len", obs.size(), 7);
      chk("lw_alu_op", ex_alu_op, 4'b0000);

      run(mkv("sw", OPC_STORE, 3'b010, 7'h00, 0, 0, 1, 0));
      run(mkv("beq_taken", OPC_BRANCH, 3'b000, 7'h00, 1, 0, 0, 0));
      run(mkv("bne_not", OPC_BRANCH, 3'b001, 7'h00, 0, 0, 0, 0));

      run(mkv("fetch_to", OPC_OP_IMM, 3'b000, 7'h00, 0, 0, TO, 0));
      chk("fetch_to_len", obs.size(), 5);
      chk("fetch_to_cause", last_cause, 2'd2);

      run(mkv("ill_irq", 7'b0000000, 3'b000, 7'h00, 0, 1, 0, 0));
      chk("ill_irq_cause", last_cause, 2'd1);
      run(mkv("mret", OPC_SYSTEM, 3'b000, 7'h18, 0, 0, 0, 0));
      run(mkv("add_irq", OPC_OP, 3'b000, 7'h00, 0, 1, 0, 0));
      chk("add_irq_cause", last_cause, 2'd3);
      run(mkv("csrrw", OPC_SYSTEM, 3'b001, 7'h00, 0, 0, 0, 0));

      run(mkv("mul", OPC_OP, 3'b000, 7'h01, 0, 0, 0, 0));
      chk("mul_len", obs.size(), HAS_M ? 8 : 3);
      chk("mul_cause", last_cause, HAS_M ? 2'd0 : 2'd1);

      run(mkv("sub", OPC_OP, 3'b000, 7'h20, 0, 0, 0, 0));
      chk("sub_alu_op", ex_alu_op, 4'b1000);
      run(mkv("srai", OPC_OP_IMM, 3'b101, 7'h20, 0, 0, 0, 0));
      chk("srai_alu_op", ex_alu_op, 4'b1101);
      run(mkv("andi", OPC_OP_IMM, 3'b111, 7'h20, 0, 0, 0, 0));
      chk("andi_alu_op", ex_alu_op, 4'b0111);

      run(mkv("lw_to", OPC_LOAD, 3'b010, 7'h00, 0, 0, 0, TO));
      chk("lw_to_cause", last_cause, 2'd2);
      run(mkv("lw_edge", OPC_LOAD, 3'b010, 7'h00, 0, 0, 0, TO - 1));
      chk("lw_edge_len", obs.size(), 8);
      run(mkv("jal", OPC_JAL, 3'b000, 7'h00, 0, 0, 0, 0));

      // reset in the third MEM wait cycle of a load
      opcode = OPC_LOAD; func3 = 3'b010; func7 = 7'h00;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("pre_rst state", state, 3'd3);
      chk("pre_rst mem_req", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst state", state, 3'd0);
      chk("rst mem_we", mem_we, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(mkv("post_rst_to", OPC_LOAD, 3'b010, 7'h00, 0, 0, TO, 0));
      chk("post_rst_len", obs.size(), 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
